// File: rtl/mp_regfile_pkg.sv
// Package for the multi-port register file.
// Holds the clear-sequencer state encoding and default parameter values.
package mp_regfile_pkg;

  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefAddrW  = 5;
  localparam int unsigned DefNumRd  = 2;
  localparam int unsigned DefBypass = 1;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

endpackage

// File: rtl/mp_regfile_if.sv
// Bus interface of the multi-port register file.
// master: drives read/debug addresses, both write ports, scoreboard set and clear request.
// slave : returns read data, busy bits, debug data and ready.
interface mp_regfile_if
  import mp_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = DefNumRd
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr0;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata0;
  logic [DATA_W-1:0]        wdata1;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     clr_req;
  logic                     ready;
  logic [ADDR_W-1:0]        disp_num_addr;
  logic [DATA_W-1:0]        disp_num;

  modport master (
    output rd_addr, we0, we1, waddr0, waddr1, wdata0, wdata1, sb_set, sb_addr, clr_req,
           disp_num_addr,
    input  rd_data, rd_busy, ready, disp_num
  );

  modport slave (
    input  rd_addr, we0, we1, waddr0, waddr1, wdata0, wdata1, sb_set, sb_addr, clr_req,
           disp_num_addr,
    output rd_data, rd_busy, ready, disp_num
  );

endinterface

// File: rtl/mp_regfile_clr_fsm.sv
// Soft-clear sequencer: walks entries 1..DEPTH-1, one per cycle, after clr_req.
// Ports: clk, reset (async, active-high), clr_req in;
//        clr_en (clearing this cycle), clr_idx (entry being cleared), ready (idle) out.
module mp_regfile_clr_fsm
  import mp_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LastIdx = {ADDR_W{1'b1}};

  clr_state_e        state;
  logic [ADDR_W-1:0] cnt;

  // Outputs are registered alongside the state so they change exactly with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StIdle;
      cnt    <= '0;
      clr_en <= 1'b0;
      ready  <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (clr_req) begin
            state  <= StClear;
            cnt    <= ADDR_W'(1);
            clr_en <= 1'b1;
            ready  <= 1'b0;
          end
        end
        StClear: begin
          if (cnt == LastIdx) begin
            state  <= StIdle;
            cnt    <= '0;
            clr_en <= 1'b0;
            ready  <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state  <= StIdle;
          cnt    <= '0;
          clr_en <= 1'b0;
          ready  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_idx = cnt;

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file: NUM_RD combinational read ports plus a debug port, two write ports,
// a per-entry busy scoreboard and a soft clear sequencer. Entry 0 always reads zero.
// Ports: clk, reset (async, active-high), bus (mp_regfile_if slave).
module mp_regfile
  import mp_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = DefNumRd,
  parameter int unsigned BYPASS = DefBypass
) (
  input  logic         clk,
  input  logic         reset,
  mp_regfile_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              ready;

  mp_regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk     (clk),
    .reset   (reset),
    .clr_req (bus.clr_req),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  logic [ADDR_W-1:0] waddr0, waddr1, sb_addr;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              wen0, wen1, sb_en;

  assign waddr0  = bus.waddr0;
  assign waddr1  = bus.waddr1;
  assign wdata0  = bus.wdata0;
  assign wdata1  = bus.wdata1;
  assign sb_addr = bus.sb_addr;

  // Qualified write/set strobes: entry 0 and anything during a clear are dropped.
  assign wen0  = bus.we0 && ready && (waddr0 != '0);
  assign wen1  = bus.we1 && ready && (waddr1 != '0);
  assign sb_en = bus.sb_set && ready && (sb_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else if (clr_en) begin
      regs[clr_idx] <= '0;
      busy[clr_idx] <= 1'b0;
    end else begin
      // Port 1 is applied after port 0 so it wins on an address collision,
      // and a scoreboard set is applied last so it wins over a write's clear.
      if (wen0) begin
        regs[waddr0] <= wdata0;
        busy[waddr0] <= 1'b0;
      end
      if (wen1) begin
        regs[waddr1] <= wdata1;
        busy[waddr1] <= 1'b0;
      end
      if (sb_en) busy[sb_addr] <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = regs[a];
    if (BYPASS != 0) begin
      if (wen0 && (waddr0 == a)) r = wdata0;
      if (wen1 && (waddr1 == a)) r = wdata1;
    end
    if (a == '0) r = '0;
    return r;
  endfunction

  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a                         = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] = read_word(a);
    assign rd_busy[k]                = (a != '0) && busy[a];
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_busy  = rd_busy;
  assign bus.disp_num = read_word(bus.disp_num_addr);
  assign bus.ready    = ready;

endmodule

// File: tb/tb_mp_regfile.sv
// Scoreboard bench for mp_regfile: stimulus pushes expected values into a queue, a negedge
// monitor pops and compares. Three instances: default (bypass), no-bypass, and narrow 4-port.
module tb_mp_regfile;

  logic clk;
  logic reset;

  mp_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  mp_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_b ();
  mp_regfile_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) bus_c ();

  mp_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_a (
    .clk (clk), .reset (reset), .bus (bus_a)
  );
  mp_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_b (
    .clk (clk), .reset (reset), .bus (bus_b)
  );
  mp_regfile #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .BYPASS(1)) u_c (
    .clk (clk), .reset (reset), .bus (bus_c)
  );

  // The no-bypass instance sees exactly the same stimulus as the bypass one.
  assign bus_b.rd_addr       = bus_a.rd_addr;
  assign bus_b.we0           = bus_a.we0;
  assign bus_b.we1           = bus_a.we1;
  assign bus_b.waddr0        = bus_a.waddr0;
  assign bus_b.waddr1        = bus_a.waddr1;
  assign bus_b.wdata0        = bus_a.wdata0;
  assign bus_b.wdata1        = bus_a.wdata1;
  assign bus_b.sb_set        = bus_a.sb_set;
  assign bus_b.sb_addr       = bus_a.sb_addr;
  assign bus_b.clr_req       = bus_a.clr_req;
  assign bus_b.disp_num_addr = bus_a.disp_num_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int KData = 0, KBusy = 1, KReady = 2, KDisp = 3;
  localparam int DA = 0, DB = 1, DC = 2;

  typedef struct {
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  function automatic logic [31:0] actual(input item_t it);
    logic [31:0] v;
    v = '0;
    case (it.dut)
      DA: case (it.kind)
        KData:  v = bus_a.rd_data[it.port*32 +: 32];
        KBusy:  v = {31'b0, bus_a.rd_busy[it.port]};
        KReady: v = {31'b0, bus_a.ready};
        default: v = bus_a.disp_num;
      endcase
      DB: case (it.kind)
        KData:  v = bus_b.rd_data[it.port*32 +: 32];
        KBusy:  v = {31'b0, bus_b.rd_busy[it.port]};
        KReady: v = {31'b0, bus_b.ready};
        default: v = bus_b.disp_num;
      endcase
      default: case (it.kind)
        KData:  v = {16'b0, bus_c.rd_data[it.port*16 +: 16]};
        KBusy:  v = {31'b0, bus_c.rd_busy[it.port]};
        KReady: v = {31'b0, bus_c.ready};
        default: v = {16'b0, bus_c.disp_num};
      endcase
    endcase
    return v;
  endfunction

  item_t mon_it;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      mon_it  = sb_q.pop_front();
      mon_act = actual(mon_it);
      n_cmp++;
      if (mon_act !== mon_it.exp) begin
        n_fail++;
        $display("FAIL %s dut=%0d port=%0d got=0x%08h want=0x%08h", mon_it.name, mon_it.dut,
                 mon_it.port, mon_act, mon_it.exp);
      end
    end
  end

  task automatic expect_v(input int dut, input int kind, input int port, input logic [31:0] v,
                          input string name);
    item_t it;
    it.dut = dut; it.kind = kind; it.port = port; it.exp = v; it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic check_direct(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.we0 = 1'b0; bus_a.we1 = 1'b0; bus_a.waddr0 = '0; bus_a.waddr1 = '0;
    bus_a.wdata0 = '0; bus_a.wdata1 = '0; bus_a.sb_set = 1'b0; bus_a.sb_addr = '0;
    bus_a.clr_req = 1'b0;
  endtask

  task automatic idle_c();
    bus_c.we0 = 1'b0; bus_c.we1 = 1'b0; bus_c.waddr0 = '0; bus_c.waddr1 = '0;
    bus_c.wdata0 = '0; bus_c.wdata1 = '0; bus_c.sb_set = 1'b0; bus_c.sb_addr = '0;
    bus_c.clr_req = 1'b0;
  endtask

  task automatic set_rd_a(input int k, input logic [4:0] a);
    bus_a.rd_addr[k*5 +: 5] = a;
  endtask

  task automatic set_rd_c(input int k, input logic [2:0] a);
    bus_c.rd_addr[k*3 +: 3] = a;
  endtask

  // Counts cycles with ready low on the given instance; bounded.
  task automatic count_busy_a(output int n);
    n = 0;
    while (bus_a.ready !== 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle_a();
    idle_c();
    bus_a.rd_addr = '0;
    bus_c.rd_addr = '0;
    bus_a.disp_num_addr = 5'd5;
    bus_c.disp_num_addr = 3'd0;
    set_rd_a(0, 5'd5);
    set_rd_a(1, 5'd3);
    #1;
    expect_v(DA, KData, 0, 32'h0, "rst_rd0");
    expect_v(DA, KData, 1, 32'h0, "rst_rd1");
    expect_v(DA, KBusy, 0, 32'h0, "rst_busy");
    expect_v(DA, KReady, 0, 32'h1, "rst_ready");
    expect_v(DA, KDisp, 0, 32'h0, "rst_disp");
    expect_v(DC, KReady, 0, 32'h1, "rst_ready_c");
    step();
    step();
    reset = 1'b0;

    // Write r5, same-cycle read: bypass forwards, no-bypass shows old value.
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd5; bus_a.wdata0 = 32'hDEADBEEF;
    set_rd_a(0, 5'd5); set_rd_a(1, 5'd0);
    expect_v(DA, KData, 0, 32'hDEADBEEF, "byp_r5");
    expect_v(DB, KData, 0, 32'h0, "nobyp_r5_old");
    expect_v(DA, KDisp, 0, 32'hDEADBEEF, "byp_disp_r5");
    expect_v(DB, KDisp, 0, 32'h0, "nobyp_disp_r5");
    step();
    // Write to r0 dropped and never forwarded.
    bus_a.waddr0 = 5'd0; bus_a.wdata0 = 32'h1234;
    expect_v(DA, KData, 0, 32'hDEADBEEF, "r5_stored_a");
    expect_v(DB, KData, 0, 32'hDEADBEEF, "r5_stored_b");
    expect_v(DA, KData, 1, 32'h0, "r0_no_bypass");
    step();
    idle_a();
    bus_a.disp_num_addr = 5'd0;
    expect_v(DA, KData, 1, 32'h0, "r0_reads_0");
    expect_v(DB, KData, 1, 32'h0, "r0_reads_0_b");
    expect_v(DA, KDisp, 0, 32'h0, "disp_r0");
    step();

    // Dual write collision on r7.
    bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd7; bus_a.wdata1 = 32'h33;
    step();
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd7; bus_a.wdata0 = 32'h11;
    bus_a.wdata1 = 32'h22;
    set_rd_a(1, 5'd7);
    bus_a.disp_num_addr = 5'd7;
    expect_v(DA, KData, 1, 32'h22, "byp_p1_wins");
    expect_v(DB, KData, 1, 32'h33, "nobyp_r7_old");
    expect_v(DA, KDisp, 0, 32'h22, "byp_disp_p1_wins");
    expect_v(DB, KDisp, 0, 32'h33, "nobyp_disp_r7");
    step();
    idle_a();
    expect_v(DA, KData, 1, 32'h22, "r7_stored_a");
    expect_v(DB, KData, 1, 32'h22, "r7_stored_b");
    step();

    // Scoreboard on r9.
    bus_a.sb_set = 1'b1; bus_a.sb_addr = 5'd9;
    set_rd_a(0, 5'd9);
    expect_v(DA, KBusy, 0, 32'h0, "busy_not_bypassed");
    step();
    idle_a();
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd9; bus_a.wdata0 = 32'h99;
    expect_v(DA, KBusy, 0, 32'h1, "busy_set");
    expect_v(DB, KBusy, 0, 32'h1, "busy_set_b");
    step();
    idle_a();
    expect_v(DA, KBusy, 0, 32'h0, "busy_cleared_by_write");
    step();
    bus_a.sb_set = 1'b1; bus_a.sb_addr = 5'd9;
    bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd9; bus_a.wdata1 = 32'h77;
    expect_v(DA, KBusy, 0, 32'h0, "busy_before_setwr");
    step();
    idle_a();
    expect_v(DA, KBusy, 0, 32'h1, "busy_set_wins");
    expect_v(DA, KData, 0, 32'h77, "r9_written");
    step();

    // Fill r1..r31 with their index, mark r12 busy, then soft clear.
    for (int i = 1; i < 32; i++) begin
      bus_a.we0 = 1'b1; bus_a.waddr0 = 5'(i); bus_a.wdata0 = 32'(i);
      step();
    end
    idle_a();
    bus_a.sb_set = 1'b1; bus_a.sb_addr = 5'd12;
    set_rd_a(0, 5'd1); set_rd_a(1, 5'd31);
    expect_v(DA, KData, 0, 32'd1, "fill_r1");
    expect_v(DA, KData, 1, 32'd31, "fill_r31");
    step();
    idle_a();
    set_rd_a(1, 5'd12);
    expect_v(DA, KBusy, 1, 32'h1, "r12_busy_pre_clear");
    bus_a.clr_req = 1'b1;
    step();
    bus_a.clr_req = 1'b0;
    n = 0;
    while (bus_a.ready !== 1'b1 && n < 100) begin
      n++;
      idle_a();
      if (n == 5) begin
        // Mid-clear: r1..r4 already zero, later entries untouched, writes ignored.
        bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd2; bus_a.wdata0 = 32'hAAAA;
        bus_a.sb_set = 1'b1; bus_a.sb_addr = 5'd3;
        set_rd_a(0, 5'd2); set_rd_a(1, 5'd12);
        expect_v(DA, KData, 0, 32'h0, "clr_r2_zero_no_byp");
        expect_v(DA, KData, 1, 32'd12, "clr_r12_not_yet");
        expect_v(DA, KBusy, 1, 32'h1, "clr_r12_busy_not_yet");
        expect_v(DA, KReady, 0, 32'h0, "clr_ready_low");
      end
      if (n == 10) bus_a.clr_req = 1'b1;
      step();
    end
    idle_a();
    check_direct("clear_cycles_31", n, 31);
    for (int i = 1; i < 32; i++) begin
      set_rd_a(0, 5'(i)); set_rd_a(1, 5'(i));
      expect_v(DA, KData, 0, 32'h0, "post_clear_data");
      expect_v(DA, KBusy, 1, 32'h0, "post_clear_busy");
      step();
    end
    expect_v(DA, KReady, 0, 32'h1, "post_clear_ready");
    step();

    // Reset in the middle of a clear.
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd30; bus_a.wdata0 = 32'h3030;
    bus_a.sb_set = 1'b1; bus_a.sb_addr = 5'd25;
    step();
    idle_a();
    bus_a.clr_req = 1'b1;
    step();
    bus_a.clr_req = 1'b0;
    repeat (8) step();
    set_rd_a(0, 5'd30); set_rd_a(1, 5'd25);
    expect_v(DA, KData, 0, 32'h3030, "pre_rst_r30");
    expect_v(DA, KBusy, 1, 32'h1, "pre_rst_busy25");
    expect_v(DA, KReady, 0, 32'h0, "pre_rst_ready_low");
    step();
    reset = 1'b1;
    #1;
    expect_v(DA, KData, 0, 32'h0, "rst_mid_clr_r30");
    expect_v(DB, KData, 0, 32'h0, "rst_mid_clr_r30_b");
    expect_v(DA, KBusy, 1, 32'h0, "rst_mid_clr_busy25");
    expect_v(DA, KReady, 0, 32'h1, "rst_mid_clr_ready");
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_v(DA, KReady, 0, 32'h1, "no_resume_ready");
    end
    step();

    // Narrow 4-port instance.
    for (int i = 1; i < 8; i++) begin
      bus_c.we0 = 1'b1; bus_c.waddr0 = 3'(i); bus_c.wdata0 = 16'(32'h100 + i);
      step();
    end
    idle_c();
    set_rd_c(0, 3'd1); set_rd_c(1, 3'd3); set_rd_c(2, 3'd5); set_rd_c(3, 3'd7);
    expect_v(DC, KData, 0, 32'h101, "c_p0_r1");
    expect_v(DC, KData, 1, 32'h103, "c_p1_r3");
    expect_v(DC, KData, 2, 32'h105, "c_p2_r5");
    expect_v(DC, KData, 3, 32'h107, "c_p3_r7");
    step();
    set_rd_c(0, 3'd2); set_rd_c(1, 3'd4); set_rd_c(2, 3'd6); set_rd_c(3, 3'd0);
    expect_v(DC, KData, 0, 32'h102, "c_p0_r2");
    expect_v(DC, KData, 1, 32'h104, "c_p1_r4");
    expect_v(DC, KData, 2, 32'h106, "c_p2_r6");
    expect_v(DC, KData, 3, 32'h0, "c_p3_r0");
    bus_c.clr_req = 1'b1;
    step();
    bus_c.clr_req = 1'b0;
    n = 0;
    while (bus_c.ready !== 1'b1 && n < 100) begin
      n++;
      step();
    end
    check_direct("c_clear_cycles_7", n, 7);
    set_rd_c(0, 3'd1); set_rd_c(1, 3'd3); set_rd_c(2, 3'd5); set_rd_c(3, 3'd7);
    expect_v(DC, KData, 0, 32'h0, "c_clr_r1");
    expect_v(DC, KData, 1, 32'h0, "c_clr_r3");
    expect_v(DC, KData, 2, 32'h0, "c_clr_r5");
    expect_v(DC, KData, 3, 32'h0, "c_clr_r7");
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
